alu_vector_recorder: RTL

- Write-side counterpart to the ALU vector-driven self-check flow.
- Captures live ALU transactions (A, B, ctrl, result) and packs them into the team's 26-bit test-vector record format: A[25:22], B[21:18], ctrl[17:16], and result fields ctrl00 [15:12], ctrl01 [11:8], ctrl10 [7:4], ctrl11 [3:0].
- Merges consecutive captures that share the same A/B pair into one record.
- Buffers completed records in a FIFO, which a host or bench drains to rebuild vector files from hardware runs.

---
 rtl/alu_vector_recorder_if.sv | 34 +++
 rtl/alu_vector_recorder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_recorder_if.sv
// Capture and read-side bus of the ALU vector recorder.
// The master side is the ALU tap and record consumer; the slave side is the recorder.
interface alu_vector_recorder_if #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16
);
   localparam int REC_W = 6*DATA_W + 2;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              clear;
   logic              cap_valid;
   logic              cap_ready;
   logic [DATA_W-1:0] cap_a;
   logic [DATA_W-1:0] cap_b;
   logic [1:0]        cap_ctrl;
   logic [DATA_W-1:0] cap_out;
   logic              flush;
   logic              rd_en;
   logic              rd_valid;
   logic [REC_W-1:0]  rd_data;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              overflow;

   modport master (
      output clear, cap_valid, cap_a, cap_b, cap_ctrl, cap_out, flush, rd_en,
      input  cap_ready, rd_valid, rd_data, count, full, overflow
   );

   modport slave (
      input  clear, cap_valid, cap_a, cap_b, cap_ctrl, cap_out, flush, rd_en,
      output cap_ready, rd_valid, rd_data, count, full, overflow
   );
endinterface

// File: rtl/alu_vector_recorder.sv
// Packs live ALU transactions into test-vector records, merging same-A/B captures, and queues them.
// Optional feature: define ALU_REC_SIGNATURE_EN to add a rolling 8-bit signature of committed records.
//
// state    | meaning
// ST_IDLE  | no pending record
// ST_ASM   | pending record being assembled, fill mask tracks captured ctrl slots
module alu_vector_recorder #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_vector_recorder_if.slave  bus
`ifdef ALU_REC_SIGNATURE_EN
   ,
   output logic [7:0]            signature
`endif
);
   localparam int REC_W = 6*DATA_W + 2;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ASM  = 1'b1;

   logic [0:0]                  state_q, state_d;
   logic [DATA_W-1:0]           a_q, a_d, b_q, b_d;
   logic [1:0]                  ctrl_q, ctrl_d;
   logic [3:0][DATA_W-1:0]      res_q, res_d, res_m;
   logic [3:0]                  mask_q, mask_d, mask_m, ctrl_hot;
   logic                        fire, pop, commit, load_new, full, same_pair;
   logic [REC_W-1:0]            commit_rec;

   logic [REC_W-1:0]            mem [DEPTH];
   logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]            count_q;
   logic                        overflow_q;

   assign full          = (count_q == CNT_W'(DEPTH));
   assign fire          = bus.cap_valid && !full;
   assign pop           = bus.rd_en && (count_q != '0);
   assign ctrl_hot      = 4'b0001 << bus.cap_ctrl;
   assign same_pair     = (bus.cap_a == a_q) && (bus.cap_b == b_q) && !mask_q[bus.cap_ctrl];

   assign bus.cap_ready = !full;
   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.rd_valid  = (count_q != '0);
   assign bus.rd_data   = (count_q != '0) ? mem[rd_ptr_q] : '0;
   assign bus.overflow  = overflow_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      ctrl_d     = ctrl_q;
      res_d      = res_q;
      mask_d     = mask_q;
      commit     = 1'b0;
      load_new   = 1'b0;
      res_m      = res_q;
      res_m[bus.cap_ctrl] = bus.cap_out;
      mask_m     = mask_q | ctrl_hot;
      commit_rec = {a_q, b_q, ctrl_q, res_q[0], res_q[1], res_q[2], res_q[3]};
      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               load_new = 1'b1;
               state_d  = ST_ASM;
            end
         end
         ST_ASM: begin
            if (fire) begin
               if (same_pair && (mask_m == 4'b1111)) begin
                  commit     = 1'b1;
                  commit_rec = {a_q, b_q, bus.cap_ctrl, res_m[0], res_m[1], res_m[2], res_m[3]};
                  mask_d     = '0;
                  state_d    = ST_IDLE;
               end else if (same_pair) begin
                  res_d  = res_m;
                  mask_d = mask_m;
                  ctrl_d = bus.cap_ctrl;
               end else begin
                  commit   = 1'b1;
                  load_new = 1'b1;
               end
            // a flush against a full FIFO waits until a slot frees rather than dropping the record
            end else if (bus.flush && (!full || pop)) begin
               commit  = 1'b1;
               mask_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_new) begin
         a_d    = bus.cap_a;
         b_d    = bus.cap_b;
         ctrl_d = bus.cap_ctrl;
         res_d  = '0;
         res_d[bus.cap_ctrl] = bus.cap_out;
         mask_d = ctrl_hot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         res_q   <= '0;
         mask_q  <= '0;
      end else if (bus.clear) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         res_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         res_q   <= res_d;
         mask_q  <= mask_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (commit) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (commit && !pop)      count_q <= count_q + CNT_W'(1);
         else if (pop && !commit) count_q <= count_q - CNT_W'(1);
         if (bus.cap_valid && full) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (commit && !bus.clear) mem[wr_ptr_q] <= commit_rec;
   end

`ifdef ALU_REC_SIGNATURE_EN
   logic [7:0] fold;

   generate
      if (REC_W == 26) begin : g_fold_default
         // ctrl bits are skipped here so the A/B pair folds in as one whole byte
         assign fold = commit_rec[7:0] ^ commit_rec[15:8] ^ commit_rec[25:18];
      end else begin : g_fold_bytes
         localparam int NB = (REC_W + 7) / 8;
         logic [NB*8-1:0] ext;
         always_comb begin
            ext = '0;
            ext[REC_W-1:0] = commit_rec;
            fold = '0;
            for (int i = 0; i < NB; i++) fold = fold ^ ext[i*8 +: 8];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         signature <= '0;
      else if (bus.clear) signature <= '0;
      else if (commit)    signature <= {signature[6:0], signature[7]} ^ fold;
   end
`endif
endmodule
